// File: rtl/cam_frame_capture.sv
// cam_frame_capture: turns a DVP-style camera byte stream (RGB565, high byte
// first) into RGB332 frame-buffer writes with linear addressing y*WIDTH+x.
// Build option: define CAM_CAPTURE_TEST_PATTERN_EN to replace the pixel data
// with vertical colour bars while keeping timing, addressing and W_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset; waiting for the first VSYNC, nothing is written
// VBLANK  | vertical blank; x, y and byte phase held cleared
// ACTIVE  | frame lines arriving; pixels assembled and written
module cam_frame_capture #(
    parameter int WIDTH  = 176,
    parameter int HEIGHT = 144
) (
    input  logic        CLK,
    input  logic        RES_N,
    input  logic        VSYNC,
    input  logic        HREF,
    input  logic [7:0]  D,
    output logic [7:0]  PIXEL,
    output logic [14:0] W_ADDR,
    output logic        W_EN,
    output logic        FRAME_DONE,
    output logic        ERR
);

    localparam int XW = $clog2(WIDTH + 1);
    localparam int YW = $clog2(HEIGHT + 1);
    localparam logic [XW-1:0] X_END = XW'(WIDTH);
    localparam logic [YW-1:0] Y_END = YW'(HEIGHT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VBLANK = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic            phase_q, phase_d;
    logic            href_q, href_d;
    logic [7:0]      pixel_q, pixel_d;
    logic [14:0]     waddr_q, waddr_d;
    logic            wen_q, wen_d;
    logic            fdone_q, fdone_d;
    logic            err_q, err_d;
    logic [14:0]     addr_cur;
    logic [7:0]      pixel_new;

`ifndef CAM_CAPTURE_TEST_PATTERN_EN
    logic [2:0]      r_q, r_d;
    logic [2:0]      g_q, g_d;
`endif

    // Linear address of the pixel at the current x,y; fits 15 bits for x<WIDTH, y<HEIGHT.
    assign addr_cur = 15'(y_q) * 15'(WIDTH) + 15'(x_q);

    // Pixel value written when the second byte of a pair arrives.
    always_comb begin
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        if (x_q < XW'(WIDTH / 3)) begin
            pixel_new = 8'hE0;
        end else if (x_q < XW'((2 * WIDTH) / 3)) begin
            pixel_new = 8'h1C;
        end else begin
            pixel_new = 8'h03;
        end
`else
        pixel_new = {r_q, g_q, D[4:3]};
`endif
    end

    // Next-state and datapath decode for the capture FSM.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        phase_d = phase_q;
        href_d  = href_q;
        pixel_d = pixel_q;
        waddr_d = waddr_q;
        wen_d   = 1'b0;
        fdone_d = 1'b0;
        err_d   = err_q;
`ifndef CAM_CAPTURE_TEST_PATTERN_EN
        r_d     = r_q;
        g_d     = g_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (VSYNC) begin
                    state_d = S_VBLANK;
                end
            end
            S_VBLANK: begin
                x_d     = '0;
                y_d     = '0;
                phase_d = 1'b0;
                href_d  = 1'b0;
                if (!VSYNC) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (VSYNC) begin
                    // Frame ends here even mid-line; a half-assembled pixel is simply dropped.
                    state_d = S_VBLANK;
                    fdone_d = 1'b1;
                    phase_d = 1'b0;
                    href_d  = 1'b0;
                end else begin
                    href_d = HREF;
                    if (HREF) begin
                        phase_d = ~phase_q;
                        if (!phase_q) begin
`ifndef CAM_CAPTURE_TEST_PATTERN_EN
                            r_d = D[7:5];
                            g_d = D[2:0];
`endif
                        end else if ((x_q < X_END) && (y_q < Y_END)) begin
                            wen_d   = 1'b1;
                            pixel_d = pixel_new;
                            waddr_d = addr_cur;
                            x_d     = x_q + XW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (href_q) begin
                        x_d     = '0;
                        phase_d = 1'b0;
                        if (y_q < Y_END) begin
                            y_d = y_q + YW'(1);
                        end
                        if (phase_q) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset also kills a write that would otherwise issue this cycle.
    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            x_q     <= '0;
            y_q     <= '0;
            phase_q <= 1'b0;
            href_q  <= 1'b0;
            pixel_q <= 8'h00;
            waddr_q <= '0;
            wen_q   <= 1'b0;
            fdone_q <= 1'b0;
            err_q   <= 1'b0;
`ifndef CAM_CAPTURE_TEST_PATTERN_EN
            r_q     <= '0;
            g_q     <= '0;
`endif
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            phase_q <= phase_d;
            href_q  <= href_d;
            pixel_q <= pixel_d;
            waddr_q <= waddr_d;
            wen_q   <= wen_d;
            fdone_q <= fdone_d;
            err_q   <= err_d;
`ifndef CAM_CAPTURE_TEST_PATTERN_EN
            r_q     <= r_d;
            g_q     <= g_d;
`endif
        end
    end

    assign PIXEL      = pixel_q;
    assign W_ADDR     = waddr_q;
    assign W_EN       = wen_q;
    assign FRAME_DONE = fdone_q;
    assign ERR        = err_q;

endmodule

// File: tb/tb_cam_frame_capture.sv
// Randomized bench for cam_frame_capture; expected writes come from a
// line/pixel-level model of the capture rules.
module tb_cam_frame_capture;

    localparam int WIDTH  = 176;
    localparam int HEIGHT = 144;

    logic        CLK = 1'b0;
    logic        RES_N = 1'b0;
    logic        VSYNC = 1'b0;
    logic        HREF = 1'b0;
    logic [7:0]  D = 8'h00;
    logic [7:0]  PIXEL;
    logic [14:0] W_ADDR;
    logic        W_EN;
    logic        FRAME_DONE;
    logic        ERR;

    int tests_run = 0;
    int tests_failed = 0;

    int          got_addr[$];
    logic [7:0]  got_pix[$];
    int          got_fd = 0;
    int          exp_addr[$];
    logic [7:0]  exp_pix[$];
    int          exp_fd = 0;
    logic        exp_err = 1'b0;
    int          ln = 0;
    bit          model_on = 1'b1;

    cam_frame_capture #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .CLK(CLK), .RES_N(RES_N), .VSYNC(VSYNC), .HREF(HREF), .D(D),
        .PIXEL(PIXEL), .W_ADDR(W_ADDR), .W_EN(W_EN),
        .FRAME_DONE(FRAME_DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (W_EN === 1'b1) begin
            got_addr.push_back(int'(W_ADDR));
            got_pix.push_back(PIXEL);
        end
        if (FRAME_DONE === 1'b1) got_fd++;
    end

    // RGB565 word -> RGB332 by keeping the top bits of each channel.
    function automatic logic [7:0] model_pix(input logic [7:0] hi, input logic [7:0] lo, input int x);
        int rgb, r3, g3, b2;
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        if (x < WIDTH / 3) return 8'hE0;
        if (x < (2 * WIDTH) / 3) return 8'h1C;
        return 8'h03;
`else
        rgb = int'(hi) * 256 + int'(lo);
        r3 = (rgb / 2048) / 4;
        g3 = ((rgb / 32) % 64) / 8;
        b2 = (rgb % 32) / 8;
        return 8'(r3 * 32 + g3 * 4 + b2);
`endif
    endfunction

    function automatic int diff_idx();
        int n;
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++)
            if (got_addr[i] !== exp_addr[i] || got_pix[i] !== exp_pix[i]) return i;
        if (got_addr.size() != exp_addr.size()) return n;
        return -1;
    endfunction

    task automatic cyc(input logic vs, input logic hr, input logic [7:0] d);
        VSYNC = vs; HREF = hr; D = d;
        @(posedge CLK); #1;
    endtask

    task automatic clear_model();
        got_addr.delete(); got_pix.delete(); exp_addr.delete(); exp_pix.delete();
        got_fd = 0; exp_fd = 0; exp_err = 1'b0; ln = 0; model_on = 1'b1;
    endtask

    task automatic do_reset();
        RES_N = 1'b0;
        cyc(1'($urandom), 1'($urandom), 8'($urandom));
        cyc(1'b0, 1'b0, 8'h00);
        RES_N = 1'b1;
        clear_model();
    endtask

    task automatic frame_start();
        repeat (3) cyc(1'b1, 1'b0, 8'($urandom));
        repeat (2) cyc(1'b0, 1'b0, 8'($urandom));
        ln = 0;
    endtask

    task automatic frame_end();
        cyc(1'b1, 1'b0, 8'h00);
        if (model_on) exp_fd++;
        repeat (3) cyc(1'b1, 1'b0, 8'h00);
    endtask

    // rnd=0 sends the constant fill byte; abort raises VSYNC right after the last byte.
    task automatic send_line(input int n, input bit rnd, input logic [7:0] fill, input bit abort);
        logic [7:0] b, b0;
        b0 = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : fill;
            if (model_on) begin
                if (i % 2 == 0) b0 = b;
                else if (i / 2 < WIDTH && ln < HEIGHT) begin
                    exp_addr.push_back(ln * WIDTH + i / 2);
                    exp_pix.push_back(model_pix(b0, b, i / 2));
                end else exp_err = 1'b1;
            end
            cyc(1'b0, 1'b1, b);
        end
        if (abort) frame_end();
        else begin
            if (model_on && (n % 2 == 1)) exp_err = 1'b1;
            repeat (2) cyc(1'b0, 1'b0, 8'($urandom));
            ln++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (PIXEL !== 8'h00) begin tests_failed++; $display("FAIL reset_pixel got %h want 00", PIXEL); end
        tests_run++;
        if (W_ADDR !== 15'd0) begin tests_failed++; $display("FAIL reset_waddr got %0d want 0", W_ADDR); end
        tests_run++;
        if (W_EN !== 1'b0) begin tests_failed++; $display("FAIL reset_wen got %b want 0", W_EN); end
        tests_run++;
        if (FRAME_DONE !== 1'b0) begin tests_failed++; $display("FAIL reset_fdone got %b want 0", FRAME_DONE); end
        tests_run++;
        if (ERR !== 1'b0) begin tests_failed++; $display("FAIL reset_err got %b want 0", ERR); end
        // Reset landing on the edge that samples a second byte must block that write.
        frame_start();
        cyc(1'b0, 1'b1, 8'hFF); cyc(1'b0, 1'b1, 8'hFF); cyc(1'b0, 1'b1, 8'hFF);
        RES_N = 1'b0;
        cyc(1'b0, 1'b1, 8'hFF);
        tests_run++;
        if (W_EN !== 1'b0) begin tests_failed++; $display("FAIL reset_midline_wen got %b want 0", W_EN); end
        RES_N = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        tests_run++;
        if (got_addr.size() !== 1) begin tests_failed++; $display("FAIL reset_midline_count got %0d want 1", got_addr.size()); end
    endtask

    task automatic test_directed_line();
        logic [7:0] p0, p1;
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        p0 = 8'hE0; p1 = 8'hE0;
`else
        p0 = 8'hE0; p1 = 8'h1C;
`endif
        do_reset();
        frame_start();
        cyc(1'b0, 1'b1, 8'hF8); cyc(1'b0, 1'b1, 8'h00);
        cyc(1'b0, 1'b1, 8'h07); cyc(1'b0, 1'b1, 8'hE0);
        repeat (3) cyc(1'b0, 1'b0, 8'h00);
        tests_run++;
        if (got_addr.size() !== 2) begin
            tests_failed++; $display("FAIL directed_count got %0d want 2", got_addr.size());
        end else begin
            tests_run++;
            if (got_addr[0] !== 0 || got_pix[0] !== p0) begin
                tests_failed++; $display("FAIL directed_px0 got addr %0d pix %h want 0 %h", got_addr[0], got_pix[0], p0);
            end
            tests_run++;
            if (got_addr[1] !== 1 || got_pix[1] !== p1) begin
                tests_failed++; $display("FAIL directed_px1 got addr %0d pix %h want 1 %h", got_addr[1], got_pix[1], p1);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int d;
        do_reset();
        RES_N = 1'b0;
        model_on = 1'b0;
        repeat (5) cyc(1'b0, 1'b1, 8'($urandom));
        RES_N = 1'b1;
        send_line(20, 1'b1, 8'h00, 1'b0);
        send_line(12, 1'b1, 8'h00, 1'b0);
        tests_run++;
        if (got_addr.size() !== 0) begin tests_failed++; $display("FAIL midframe_nowrite got %0d writes want 0", got_addr.size()); end
        model_on = 1'b1;
        frame_start();
        send_line(8, 1'b1, 8'h00, 1'b0);
        frame_end();
        d = diff_idx();
        tests_run++;
        if (d !== -1) begin tests_failed++; $display("FAIL midframe_stream first diff at %0d (got %0d writes, want %0d)", d, got_addr.size(), exp_addr.size()); end
        tests_run++;
        if (ERR !== 1'b0) begin tests_failed++; $display("FAIL midframe_err got %b want 0", ERR); end
    endtask

    task automatic test_odd_line();
        int d;
        do_reset();
        frame_start();
        send_line(353, 1'b1, 8'h00, 1'b0);
        send_line(4, 1'b1, 8'h00, 1'b0);
        frame_end();
        d = diff_idx();
        tests_run++;
        if (d !== -1) begin tests_failed++; $display("FAIL odd_stream first diff at %0d (got %0d writes, want %0d)", d, got_addr.size(), exp_addr.size()); end
        tests_run++;
        if (got_addr.size() !== 178) begin tests_failed++; $display("FAIL odd_count got %0d want 178", got_addr.size()); end
        tests_run++;
        if (ERR !== 1'b1) begin tests_failed++; $display("FAIL odd_err got %b want 1", ERR); end
    endtask

    task automatic test_vsync_abort();
        int d;
        do_reset();
        frame_start();
        for (int l = 0; l < 3; l++) send_line(20, 1'b1, 8'h00, 1'b0);
        send_line(10, 1'b1, 8'h00, 1'b1);
        tests_run++;
        if (got_addr.size() !== 35) begin tests_failed++; $display("FAIL abort_count got %0d want 35", got_addr.size()); end
        tests_run++;
        if (got_fd !== 1) begin tests_failed++; $display("FAIL abort_fdone got %0d want 1", got_fd); end
        frame_start();
        send_line(6, 1'b1, 8'h00, 1'b0);
        frame_end();
        d = diff_idx();
        tests_run++;
        if (d !== -1) begin tests_failed++; $display("FAIL abort_stream first diff at %0d (got %0d writes, want %0d)", d, got_addr.size(), exp_addr.size()); end
        tests_run++;
        if (ERR !== exp_err) begin tests_failed++; $display("FAIL abort_err got %b want %b", ERR, exp_err); end
    endtask

    task automatic test_overflow();
        int d;
        do_reset();
        frame_start();
        send_line(356, 1'b1, 8'h00, 1'b0);
        frame_end();
        d = diff_idx();
        tests_run++;
        if (d !== -1) begin tests_failed++; $display("FAIL xovf_stream first diff at %0d (got %0d writes, want %0d)", d, got_addr.size(), exp_addr.size()); end
        tests_run++;
        if (ERR !== 1'b1) begin tests_failed++; $display("FAIL xovf_err got %b want 1", ERR); end
        do_reset();
        frame_start();
        for (int l = 0; l < HEIGHT + 2; l++) send_line(2, 1'b1, 8'h00, 1'b0);
        frame_end();
        d = diff_idx();
        tests_run++;
        if (d !== -1) begin tests_failed++; $display("FAIL yovf_stream first diff at %0d (got %0d writes, want %0d)", d, got_addr.size(), exp_addr.size()); end
        tests_run++;
        if (ERR !== 1'b1) begin tests_failed++; $display("FAIL yovf_err got %b want 1", ERR); end
    endtask

    task automatic test_random();
        int d, nl;
        do_reset();
        for (int f = 0; f < 4; f++) begin
            frame_start();
            nl = $urandom_range(1, 6);
            for (int l = 0; l < nl; l++)
                send_line($urandom_range(0, 40), 1'b1, 8'h00, (l == nl - 1) && ($urandom_range(0, 1) == 1));
            if (VSYNC !== 1'b1) frame_end();
            d = diff_idx();
            tests_run++;
            if (d !== -1) begin tests_failed++; $display("FAIL rand_stream frame %0d first diff at %0d (got %0d writes, want %0d)", f, d, got_addr.size(), exp_addr.size()); end
            tests_run++;
            if (got_fd !== exp_fd) begin tests_failed++; $display("FAIL rand_fdone frame %0d got %0d want %0d", f, got_fd, exp_fd); end
            tests_run++;
            if (ERR !== exp_err) begin tests_failed++; $display("FAIL rand_err frame %0d got %b want %b", f, ERR, exp_err); end
        end
    endtask

    task automatic test_full_frame();
        int d;
        do_reset();
        frame_start();
        for (int l = 0; l < HEIGHT; l++) send_line(2 * WIDTH, 1'b0, 8'hFF, 1'b0);
        frame_end();
        d = diff_idx();
        tests_run++;
        if (d !== -1) begin tests_failed++; $display("FAIL full_stream first diff at %0d (got %0d writes, want %0d)", d, got_addr.size(), exp_addr.size()); end
        tests_run++;
        if (got_addr.size() !== 25344) begin
            tests_failed++; $display("FAIL full_count got %0d want 25344", got_addr.size());
        end else begin
            tests_run++;
            if (got_addr[25343] !== 25343) begin tests_failed++; $display("FAIL full_last_addr got %0d want 25343", got_addr[25343]); end
`ifndef CAM_CAPTURE_TEST_PATTERN_EN
            tests_run++;
            if (got_pix[25343] !== 8'hFF) begin tests_failed++; $display("FAIL full_last_pix got %h want ff", got_pix[25343]); end
`endif
        end
        tests_run++;
        if (got_fd !== 1) begin tests_failed++; $display("FAIL full_fdone got %0d want 1", got_fd); end
        tests_run++;
        if (ERR !== 1'b0) begin tests_failed++; $display("FAIL full_err got %b want 0", ERR); end
    endtask

    initial begin
        test_reset();
        test_directed_line();
        test_reset_midframe();
        test_odd_line();
        test_vsync_abort();
        test_overflow();
        test_random();
        test_full_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cam_frame_capture.md
CAM_FRAME_CAPTURE -- requirements
Module: cam_frame_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 176, stored frame width in pixels.
REQ-002 The block SHALL have parameter HEIGHT, default 144, stored frame height in lines.
REQ-003 The block SHALL have port CLK  input  1  camera pixel clock; the only clock.
REQ-004 The block SHALL have port RES_N  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port VSYNC  input  1  camera frame sync, high during vertical blank.
REQ-006 The block SHALL have port HREF  input  1  camera line valid, high while line bytes are presented.
REQ-007 The block SHALL have port D  input  8  camera data byte, RGB565 sent as two bytes, high byte first.
REQ-008 The block SHALL have port PIXEL  output  8  RGB332 pixel {R[2:0],G[2:0],B[1:0]}.
REQ-009 The block SHALL have port W_ADDR  output  15  frame-buffer write address, y*WIDTH+x.
REQ-010 The block SHALL have port W_EN  output  1  one-cycle write strobe qualifying PIXEL and W_ADDR.
REQ-011 The block SHALL have port FRAME_DONE  output  1  one-cycle pulse at end of each captured frame.
REQ-012 The block SHALL have port ERR  output  1  sticky flag for malformed line or frame geometry.

Function
REQ-013 The block SHALL sample VSYNC, HREF and D on rising CLK; all outputs registered.
REQ-014 The block SHALL implement states IDLE, VBLANK, ACTIVE.
REQ-015 IDLE SHALL go to VBLANK on VSYNC=1; no writes in IDLE, so a partial frame after reset is never stored.
REQ-016 VBLANK SHALL go to ACTIVE on VSYNC=0, clearing x, y and byte phase.
REQ-017 ACTIVE SHALL go to VBLANK on VSYNC=1 and pulse FRAME_DONE for one cycle on that transition.
REQ-018 In ACTIVE with HREF=1, byte phase SHALL toggle each cycle; phase 0 latches D[7:5] as R and D[2:0] as G; phase 1 takes D[4:3] as B.
REQ-019 W_EN SHALL assert the cycle after the phase-1 byte is sampled, with PIXEL and W_ADDR for the current x,y; x then increments by 1.
REQ-020 The first HREF=0 cycle after HREF=1 SHALL reset x and byte phase to 0 and increment y by 1.
REQ-021 Pixels with x>=WIDTH or y>=HEIGHT SHALL be dropped with no W_EN, and ERR set.
REQ-022 HREF falling with byte phase 1 (odd byte count) SHALL discard the partial pixel and set ERR.
REQ-023 VSYNC rising mid-line SHALL abort the line, discard any partial pixel, and still pulse FRAME_DONE.
REQ-024 W_ADDR SHALL be computed to 15 bits without overflow for all x<WIDTH, y<HEIGHT; the maximum is 25343 at defaults.
REQ-025 x and y counters SHALL saturate at WIDTH and HEIGHT and SHALL NOT wrap.

Reset
REQ-026 With RES_N=0 at a rising CLK, the block SHALL enter IDLE and clear x, y and byte phase.
REQ-027 Reset SHALL drive PIXEL=0x00, W_ADDR=0, W_EN=0, FRAME_DONE=0, ERR=0.
REQ-028 Reset mid-line SHALL suppress any pending W_EN in the same cycle.
REQ-029 ERR SHALL clear only on reset.

Configuration
REQ-030 Macro CAM_CAPTURE_TEST_PATTERN_EN defined: PIXEL SHALL ignore D and output colour bars, with the same timing, addressing and W_EN.
REQ-031 Colour bars: x<WIDTH/3 -> 0xE0, x<2*WIDTH/3 -> 0x1C, else 0x03.
REQ-032 Macro undefined: PIXEL SHALL come from D per REQ-018.

Verification
REQ-033 Reset, VSYNC 1->0, one line HREF high 4 cycles, D=0xF8,0x00,0x07,0xE0 -> W_EN at x=0 with PIXEL=0xE0, then x=1 with PIXEL=0x1C, W_ADDR 0 and 1.
REQ-034 Full 176x144 frame of 0xFF bytes -> exactly 25344 W_EN pulses, last W_ADDR=25343, PIXEL=0xFF, one FRAME_DONE pulse, ERR=0.
REQ-035 Release reset mid-frame with VSYNC=0 -> no W_EN until a VSYNC high/low pair; the next frame is captured from address 0.
REQ-036 Line of 353 bytes -> 176 writes, partial pixel dropped, ERR=1, next line starts at W_ADDR=176.
REQ-037 VSYNC rises after 10 bytes of line 3 -> 5 writes for that line, FRAME_DONE pulses once, next frame restarts at W_ADDR=0.
REQ-038 With CAM_CAPTURE_TEST_PATTERN_EN defined, one line -> PIXEL=0xE0 at x=0, 0x1C at x=58, 0x03 at x=117 and 175.
